pwm_capture: RTL

Measures an incoming PWM waveform and reports its high time, period and duty cycle as an integer percentage 0..100, the same scale used by the duty-cycle input of our LED PWM generator. It sits on the receive side of a PWM link, e.g. fed from a generator output or a GPIO pin, so firmware and test logic can read back the applied duty cycle. The input is asynchronous and is synchronised internally. A multi-cycle divider converts counts to percent.

---
 rtl/pwm_capture.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of an asynchronous PWM input and
// converts them to an integer duty-cycle percentage with a serial restoring divider.
module pwm_capture #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [6:0]       duty,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             busy,
    output logic             ovr,
    output logic             stale
);

    localparam int unsigned      NUM_W   = CNT_W + 7;
    localparam int unsigned      IT_W    = $clog2(NUM_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
    localparam logic [NUM_W-1:0] PCT_100 = NUM_W'(100);
    localparam logic [IT_W-1:0]  IT_INIT = IT_W'(NUM_W);

    typedef enum logic {
        S_IDLE,
        S_MEAS
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic [CNT_W-1:0]   r_hi_run;
    logic [CNT_W-1:0]   r_per_run;
    logic               r_hi_en;

    logic [NUM_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_den;
    logic [CNT_W-1:0]   r_rem;
    logic [NUM_W-1:0]   r_quo;
    logic [IT_W-1:0]    r_iter;

    logic [6:0]         r_duty;
    logic [CNT_W-1:0]   r_high;
    logic [CNT_W-1:0]   r_period;
    logic               r_valid;
    logic               r_busy;
    logic               r_ovr;
    logic               r_stale;

    logic               w_rise;
    logic               w_fall;
    logic               w_timeout;
    logic               w_restart;
    logic               w_start;
    logic               w_ovr;
    logic               w_to;
    logic [CNT_W:0]     w_rem_sh;
    logic [CNT_W-1:0]   w_rem_sub;
    logic               w_ge;
    logic [NUM_W-1:0]   w_quo_next;
    logic               w_last;
    logic [6:0]         w_duty_res;
    logic [NUM_W-1:0]   w_num_init;

    assign w_rise    = r_sync2 & ~r_sync3;
    assign w_fall    = ~r_sync2 & r_sync3;
    // A rise in the same cycle as the timeout wins.
    assign w_timeout = (r_per_run == TO_CNT) && !w_rise;

    assign w_num_init = NUM_W'(r_hi_run) * PCT_100;
    assign w_rem_sh   = {r_rem, r_num[NUM_W-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_den});
    assign w_rem_sub  = w_rem_sh[CNT_W-1:0] - r_den;
    assign w_quo_next = {r_quo[NUM_W-2:0], w_ge};
    assign w_last     = r_busy && (r_iter == IT_W'(1));

    always_comb begin
        w_duty_res = w_quo_next[6:0];
        if (w_quo_next > PCT_100) begin
            w_duty_res = 7'd100;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_start      = 1'b0;
        w_ovr        = 1'b0;
        w_to         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_restart    = 1'b1;
                    w_state_next = S_MEAS;
                end else if (w_timeout) begin
                    w_to = 1'b1;
                end
            end
            S_MEAS: begin
                if (w_rise) begin
                    w_restart = 1'b1;
                    if (r_busy) begin
                        w_ovr = 1'b1;
                    end else begin
                        w_start = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_to         = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync3   <= 1'b0;
            r_hi_run  <= '0;
            r_per_run <= '0;
            r_hi_en   <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_restart) begin
                r_per_run <= CNT_W'(1);
                r_hi_run  <= CNT_W'(1);
                r_hi_en   <= 1'b1;
            end else if (w_to) begin
                r_per_run <= '0;
                r_hi_run  <= '0;
                r_hi_en   <= 1'b0;
            end else begin
                if (r_per_run != CNT_MAX) begin
                    r_per_run <= r_per_run + 1'b1;
                end
                if (w_fall) begin
                    r_hi_en <= 1'b0;
                end else if (r_hi_en && (r_hi_run != CNT_MAX)) begin
                    r_hi_run <= r_hi_run + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_num    <= '0;
            r_den    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_iter   <= '0;
            r_duty   <= '0;
            r_high   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
            r_stale  <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            r_ovr   <= w_ovr;
            if (w_to) begin
                r_busy   <= 1'b0;
                r_high   <= '0;
                r_period <= '0;
                r_duty   <= r_sync2 ? 7'd100 : 7'd0;
                r_valid  <= 1'b1;
                r_stale  <= 1'b1;
            end else if (w_start) begin
                r_high   <= r_hi_run;
                r_period <= r_per_run;
                r_num    <= w_num_init;
                r_den    <= r_per_run;
                r_rem    <= '0;
                r_quo    <= '0;
                r_iter   <= IT_INIT;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                r_num  <= {r_num[NUM_W-2:0], 1'b0};
                r_rem  <= w_ge ? w_rem_sub : w_rem_sh[CNT_W-1:0];
                r_quo  <= w_quo_next;
                r_iter <= r_iter - 1'b1;
                if (w_last) begin
                    r_busy  <= 1'b0;
                    r_duty  <= w_duty_res;
                    r_valid <= 1'b1;
                    r_stale <= 1'b0;
                end
            end
        end
    end

    assign duty       = r_duty;
    assign high_cnt   = r_high;
    assign period_cnt = r_period;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign ovr        = r_ovr;
    assign stale      = r_stale;

endmodule
